// File: rtl/tail_light_seq_if.sv
// Lamp controller bus: driver-side request levels and lamp-side outputs.
//   left, right, haz, brake : request levels (master -> slave)
//   l_lamp, r_lamp          : lamp patterns, bit 0 innermost (slave -> master)
//   busy                    : a sequence is in progress (slave -> master)
interface tail_light_seq_if #(
    parameter int LAMPS = 3
);
    logic             left;
    logic             right;
    logic             haz;
    logic             brake;
    logic [LAMPS-1:0] l_lamp;
    logic [LAMPS-1:0] r_lamp;
    logic             busy;

    modport master (
        output left, right, haz, brake,
        input  l_lamp, r_lamp, busy
    );

    modport slave (
        input  left, right, haz, brake,
        output l_lamp, r_lamp, busy
    );
endinterface

// File: rtl/tail_light_seq.sv
// Sequential turn/hazard/brake tail-light controller.
// Each side shows an outward-growing thermometer pattern, one step per DIV
// clocks. Hazard pre-empts an active turn. Brake lights the non-signalling
// side(s) fully, one clock after the pedal.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : tail_light_seq_if.slave (requests in, lamps/busy out)
module tail_light_seq #(
    parameter int LAMPS = 3,
    parameter int DIV   = 4
) (
    input  logic            clk,
    input  logic            rst,
    tail_light_seq_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW = $clog2(LAMPS + 1);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} mode_t;

    mode_t          mode, mode_nx;
    logic [PW-1:0]  pos, pos_nx;
    logic [CW-1:0]  cnt;
    logic           brake_q;
    logic           tick;
    logic [LAMPS-1:0] therm;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            mode    <= IDLE;
            pos     <= '0;
            brake_q <= 1'b0;
        end else begin
            cnt     <= tick ? '0 : cnt + CW'(1);
            brake_q <= bus.brake;
            mode    <= mode_nx;
            pos     <= pos_nx;
        end
    end

    always_comb begin
        mode_nx = mode;
        pos_nx  = pos;
        if (tick) begin
            if (mode == IDLE) begin
                if (bus.haz || (bus.left && bus.right)) begin
                    mode_nx = HAZ;
                    pos_nx  = PW'(1);
                end else if (bus.left) begin
                    mode_nx = LEFT;
                    pos_nx  = PW'(1);
                end else if (bus.right) begin
                    mode_nx = RIGHT;
                    pos_nx  = PW'(1);
                end
            end else if ((mode == LEFT || mode == RIGHT) && bus.haz) begin
                // hazard restarts from the innermost lamp
                mode_nx = HAZ;
                pos_nx  = PW'(1);
            end else if (pos == PW'(LAMPS)) begin
                // one all-off step; a held level restarts from IDLE next tick
                mode_nx = IDLE;
                pos_nx  = '0;
            end else begin
                pos_nx = pos + PW'(1);
            end
        end
    end

    // thermometer: low `pos` bits set
    always_comb begin
        therm = '0;
        for (int i = 0; i < LAMPS; i++)
            therm[i] = (PW'(i) < pos);
    end

    always_comb begin
        bus.l_lamp = '0;
        bus.r_lamp = '0;
        unique case (mode)
            IDLE: begin
                if (brake_q) begin
                    bus.l_lamp = '1;
                    bus.r_lamp = '1;
                end
            end
            LEFT: begin
                bus.l_lamp = therm;
                if (brake_q) bus.r_lamp = '1;
            end
            RIGHT: begin
                bus.r_lamp = therm;
                if (brake_q) bus.l_lamp = '1;
            end
            HAZ: begin
                bus.l_lamp = therm;
                bus.r_lamp = therm;
            end
            default: ;
        endcase
    end

    assign bus.busy = (mode != IDLE);
endmodule

// File: tb/tb_tail_light_seq.sv
// Directed bench for tail_light_seq: LAMPS=3/DIV=4 instance plus a
// LAMPS=5/DIV=1 instance sharing clock and reset.
module tb_tail_light_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tail_light_seq_if #(.LAMPS(3)) bus3 ();
    tail_light_seq_if #(.LAMPS(5)) bus5 ();

    tail_light_seq #(.LAMPS(3), .DIV(4)) dut  (.clk(clk), .rst(rst), .bus(bus3));
    tail_light_seq #(.LAMPS(5), .DIV(1)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // advance n rising edges, then sample/drive 1 time unit later
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic l, input logic r, input logic h, input logic b);
        bus3.left  = l;
        bus3.right = r;
        bus3.haz   = h;
        bus3.brake = b;
    endtask

    // reset edge, then release; the next rising edge is edge 1
    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic chk3(input string tag, input logic [2:0] l, input logic [2:0] r, input logic b);
        check({tag, ".l"}, 8'(bus3.l_lamp), 8'(l));
        check({tag, ".r"}, 8'(bus3.r_lamp), 8'(r));
        check({tag, ".busy"}, 8'(bus3.busy), 8'(b));
    endtask

    logic [4:0] exp5 [0:6];

    initial begin
        set_in(0, 0, 0, 0);
        bus5.left = 0; bus5.right = 0; bus5.haz = 0; bus5.brake = 0;
        step(2);

        // reset state
        do_reset();
        chk3("rst", 3'b000, 3'b000, 1'b0);

        // 1. left held
        set_in(1, 0, 0, 0);
        do_reset();
        step(3);  chk3("t1.e3",  3'b000, 3'b000, 1'b0);
        step(1);  chk3("t1.e4",  3'b001, 3'b000, 1'b1);
        step(4);  chk3("t1.e8",  3'b011, 3'b000, 1'b1);
        step(4);  chk3("t1.e12", 3'b111, 3'b000, 1'b1);
        step(4);  chk3("t1.e16", 3'b000, 3'b000, 1'b0);
        step(4);  chk3("t1.e20", 3'b001, 3'b000, 1'b1);

        // 2. left+right acts as hazard
        set_in(1, 1, 0, 0);
        do_reset();
        step(4);  chk3("t2.e4",  3'b001, 3'b001, 1'b1);
        step(4);  chk3("t2.e8",  3'b011, 3'b011, 1'b1);
        step(4);  chk3("t2.e12", 3'b111, 3'b111, 1'b1);
        set_in(0, 0, 0, 0);
        step(4);  chk3("t2.e16", 3'b000, 3'b000, 1'b0);

        // 3. hazard pre-empts right turn
        set_in(0, 1, 0, 0);
        do_reset();
        step(4);  chk3("t3.e4",  3'b000, 3'b001, 1'b1);
        step(1);
        set_in(0, 0, 1, 0);
        step(3);  chk3("t3.e8",  3'b001, 3'b001, 1'b1);
        step(4);  chk3("t3.e12", 3'b011, 3'b011, 1'b1);
        set_in(0, 0, 0, 0);

        // 4. brake overlay
        set_in(0, 0, 0, 1);
        do_reset();
        chk3("t4.e0", 3'b000, 3'b000, 1'b0);
        step(1);  chk3("t4.e1", 3'b111, 3'b111, 1'b0);
        set_in(1, 0, 0, 1);
        step(3);  chk3("t4.e4", 3'b001, 3'b111, 1'b1);
        set_in(1, 0, 0, 0);
        step(1);  chk3("t4.e5", 3'b001, 3'b000, 1'b1);

        // 4b. brake has no effect in hazard
        set_in(0, 0, 1, 1);
        do_reset();
        step(4);  chk3("t4.haz", 3'b001, 3'b001, 1'b1);

        // 5. reset mid-sequence
        set_in(1, 0, 0, 0);
        do_reset();
        step(8);  chk3("t5.e8", 3'b011, 3'b000, 1'b1);
        rst = 1'b1;
        step(1);  chk3("t5.rst", 3'b000, 3'b000, 1'b0);
        check("t5.cnt", 8'(dut.cnt), 8'd0);
        rst = 1'b0;
        step(3);  chk3("t5.e3", 3'b000, 3'b000, 1'b0);
        step(1);  chk3("t5.e4", 3'b001, 3'b000, 1'b1);
        set_in(0, 0, 0, 0);

        // 6. LAMPS=5, DIV=1, right held
        exp5[0] = 5'b00001; exp5[1] = 5'b00011; exp5[2] = 5'b00111;
        exp5[3] = 5'b01111; exp5[4] = 5'b11111; exp5[5] = 5'b00000;
        exp5[6] = 5'b00001;
        bus5.right = 1'b1;
        do_reset();
        check("t6.e0", 8'(bus5.r_lamp), 8'd0);
        for (int i = 0; i < 7; i++) begin
            step(1);
            check($sformatf("t6.e%0d.r", i + 1), 8'(bus5.r_lamp), 8'(exp5[i]));
            check($sformatf("t6.e%0d.l", i + 1), 8'(bus5.l_lamp), 8'd0);
        end
        bus5.right = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
